// File: rtl/bcd_digit_scanner.sv
// Time-multiplexed BCD digit scanner with blanking gaps and frame-synchronous double buffering.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_digit_scanner #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int unsigned CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] P_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] B_LAST   = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e                       r_state;
  logic [CNT_W-1:0]             r_cnt;
  logic [IDX_W-1:0]             r_idx;
  logic [NUM_DIGITS-1:0][3:0]   r_pend;
  logic [NUM_DIGITS-1:0][3:0]   r_active;
  logic [NUM_DIGITS-1:0]        r_pdp;
  logic [NUM_DIGITS-1:0]        r_adp;

  logic [NUM_DIGITS-1:0][3:0]   w_pend_nxt;
  logic [NUM_DIGITS-1:0]        w_pdp_nxt;
  logic [IDX_W-1:0]             w_idx_inc;
  logic [NUM_DIGITS-1:0]        w_lz_mask;
  logic [NUM_DIGITS-1:0]        w_sel_cur;
  logic [NUM_DIGITS-1:0]        w_sel_inc;
  logic                         w_slot_end;
  logic                         w_commit;

  // A load on the commit edge is forwarded so the freshly loaded value is what gets committed.
  assign w_pend_nxt = load ? digits_in : r_pend;
  assign w_pdp_nxt  = load ? dp_in : r_pdp;

  assign w_idx_inc  = r_idx + 1'b1;
  assign w_slot_end = (r_state == StShow) && (r_cnt == P_LAST);
  assign w_commit   = (r_state == StIdle) || (w_slot_end && (r_idx == IDX_LAST));
  assign w_sel_cur  = (NUM_DIGITS'(1) << r_idx) & ~w_lz_mask;
  assign w_sel_inc  = (NUM_DIGITS'(1) << w_idx_inc) & ~w_lz_mask;

`ifdef LEADING_ZERO_BLANK_EN
  logic w_upper_zero;

  // Walk from the most significant digit down; digit 0 is never suppressed.
  always_comb begin
    w_lz_mask    = '0;
    w_upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_upper_zero = w_upper_zero && (r_active[i] == 4'd0);
      w_lz_mask[i] = w_upper_zero && !r_adp[i];
    end
  end
`else
  assign w_lz_mask = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_pend     <= '0;
      r_pdp      <= '0;
      r_active   <= '0;
      r_adp      <= '0;
      bcd_out    <= '0;
      digit_en   <= '0;
      dp_out     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      r_pend     <= w_pend_nxt;
      r_pdp      <= w_pdp_nxt;
      if (!enable) begin
        r_state  <= StIdle;
        r_idx    <= '0;
        r_cnt    <= '0;
        digit_en <= '0;
        bcd_out  <= '0;
        dp_out   <= 1'b0;
      end else if (w_commit) begin
        r_active   <= w_pend_nxt;
        r_adp      <= w_pdp_nxt;
        r_idx      <= '0;
        r_cnt      <= '0;
        bcd_out    <= w_pend_nxt[0];
        dp_out     <= w_pdp_nxt[0];
        frame_done <= (r_state == StShow);
        if (BLANK_CYCLES == 0) begin
          r_state  <= StShow;
          digit_en <= NUM_DIGITS'(1);
        end else begin
          r_state  <= StBlank;
          digit_en <= '0;
        end
      end else begin
        case (r_state)
          StBlank: begin
            if (r_cnt == B_LAST) begin
              r_cnt    <= '0;
              r_state  <= StShow;
              digit_en <= w_sel_cur;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          StShow: begin
            if (w_slot_end) begin
              r_cnt   <= '0;
              r_idx   <= w_idx_inc;
              bcd_out <= r_active[w_idx_inc];
              dp_out  <= r_adp[w_idx_inc];
              if (BLANK_CYCLES == 0) begin
                digit_en <= w_sel_inc;
              end else begin
                r_state  <= StBlank;
                digit_en <= '0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Bench for bcd_digit_scanner: two configurations driven in parallel, checked every cycle against
// a frame-position model, plus literal expectations for the scan sequence, updates and reset.
module tb_bcd_digit_scanner;

  localparam int N = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ_ON = 1'b1;
`else
  localparam bit LZ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  bcd_a, bcd_b, den_a, den_b;
  logic        dp_a, dp_b, fd_a, fd_b;

  bcd_digit_scanner #(.NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .bcd_out(bcd_a), .digit_en(den_a), .dp_out(dp_a), .frame_done(fd_a)
  );

  bcd_digit_scanner #(.NUM_DIGITS(4), .PRESCALE(1), .BLANK_CYCLES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .bcd_out(bcd_b), .digit_en(den_b), .dp_out(dp_b), .frame_done(fd_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int p_cyc[2] = '{4, 1};
  int b_cyc[2] = '{2, 0};

  // Model: each instance is either idle or at a position within its frame.
  bit          m_idle[2];
  int          m_pos[2];
  bit          m_fd[2];
  logic [15:0] m_act[2];
  logic [3:0]  m_adp[2];
  logic [15:0] m_pend;
  logic [3:0]  m_pdp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idle[k] = 1'b1;
      m_pos[k]  = 0;
      m_fd[k]   = 1'b0;
      m_act[k]  = '0;
      m_adp[k]  = '0;
    end
    m_pend = '0;
    m_pdp  = '0;
  endtask

  task automatic model_step();
    if (load) begin
      m_pend = digits_in;
      m_pdp  = dp_in;
    end
    for (int k = 0; k < 2; k++) begin
      m_fd[k] = 1'b0;
      if (!enable) begin
        m_idle[k] = 1'b1;
        m_pos[k]  = 0;
      end else if (m_idle[k]) begin
        m_idle[k] = 1'b0;
        m_pos[k]  = 0;
        m_act[k]  = m_pend;
        m_adp[k]  = m_pdp;
      end else begin
        m_pos[k]++;
        if (m_pos[k] == N * (p_cyc[k] + b_cyc[k])) begin
          m_pos[k] = 0;
          m_fd[k]  = 1'b1;
          m_act[k] = m_pend;
          m_adp[k] = m_pdp;
        end
      end
    end
  endtask

  function automatic int slot_of(input int k);
    return m_pos[k] / (p_cyc[k] + b_cyc[k]);
  endfunction

  function automatic bit lz_sup(input int k, input int slot);
    logic [15:0] v;
    v = m_act[k] >> (4 * slot);
    return LZ_ON && (slot > 0) && !m_adp[k][slot] && (v == 16'h0);
  endfunction

  function automatic logic [3:0] exp_den(input int k);
    int slot, off;
    slot = slot_of(k);
    off  = m_pos[k] % (p_cyc[k] + b_cyc[k]);
    if (m_idle[k] || off < b_cyc[k] || lz_sup(k, slot)) return 4'b0;
    return 4'(1 << slot);
  endfunction

  function automatic logic [3:0] exp_bcd(input int k);
    logic [15:0] v;
    v = m_act[k];
    return v[4*slot_of(k) +: 4];
  endfunction

  function automatic logic [3:0] o_den(input int k);
    return (k == 0) ? den_a : den_b;
  endfunction
  function automatic logic [3:0] o_bcd(input int k);
    return (k == 0) ? bcd_a : bcd_b;
  endfunction
  function automatic logic o_dp(input int k);
    return (k == 0) ? dp_a : dp_b;
  endfunction
  function automatic logic o_fd(input int k);
    return (k == 0) ? fd_a : fd_b;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_den%0d", k), o_den(k), exp_den(k));
      chk($sformatf("model_fd%0d", k), o_fd(k), m_fd[k]);
      if (!m_idle[k]) begin
        chk($sformatf("model_bcd%0d", k), o_bcd(k), exp_bcd(k));
        chk($sformatf("model_dp%0d", k), o_dp(k), m_adp[k][slot_of(k)]);
      end
    end
  end

  task automatic wait_den(input logic [3:0] pat, input string nm);
    int i;
    i = 0;
    while (den_a !== pat && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk({nm, "_wait"}, den_a, pat);
  endtask

  task automatic wait_fd(input int k, input string nm);
    int i;
    i = 0;
    while (o_fd(k) !== 1'b1 && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk({nm, "_fd_wait"}, o_fd(k), 1'b1);
  endtask

  task automatic measure(input int k, input int exp);
    int i;
    wait_fd(k, "period");
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (o_fd(k) !== 1'b1 && i < 200);
    chk($sformatf("period%0d", k), i, exp);
  endtask

  task automatic lz_case(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] exp);
    logic [3:0] seen;
    load      = 1'b1;
    digits_in = d;
    dp_in     = dp;
    @(negedge clk);
    load = 1'b0;
    wait_fd(0, "lz");
    seen = '0;
    repeat (24) begin
      seen |= den_a;
      @(negedge clk);
    end
    chk($sformatf("lz_seen_%04h_%b", d, dp), seen, exp);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_den", den_a, 4'b0);
    chk("rst_bcd", bcd_a, 4'h0);
    chk("rst_dp", dp_a, 1'b0);
    chk("rst_fd", fd_a, 1'b0);
    chk("rst_den_b", den_b, 4'b0);
    rst_n = 1'b1;

    // Load while disabled, then start scanning.
    @(negedge clk);
    load = 1'b1; digits_in = 16'h9381; dp_in = 4'b0010;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_den", den_a, 4'b0);
    chk("idle_fd", fd_a, 1'b0);
    enable = 1'b1;
    wait_den(4'b0001, "scan0"); chk("scan0_bcd", bcd_a, 4'h1); chk("scan0_dp", dp_a, 1'b0);
    wait_den(4'b0010, "scan1"); chk("scan1_bcd", bcd_a, 4'h8); chk("scan1_dp", dp_a, 1'b1);
    wait_den(4'b0100, "scan2"); chk("scan2_bcd", bcd_a, 4'h3);
    wait_den(4'b1000, "scan3"); chk("scan3_bcd", bcd_a, 4'h9);
    measure(0, 24);
    measure(1, 4);
    wait_fd(1, "fast");
    chk("fast_d0", den_b, 4'b0001);
    @(negedge clk);
    chk("fast_d1", den_b, 4'b0010);

    // Mid-frame load must not tear the current frame.
    wait_den(4'b0010, "tear1"); chk("tear1_bcd", bcd_a, 4'h8);
    load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    wait_den(4'b0100, "tear2"); chk("tear2_bcd", bcd_a, 4'h3);
    wait_den(4'b1000, "tear3"); chk("tear3_bcd", bcd_a, 4'h9);
    wait_den(4'b0001, "new0"); chk("new0_bcd", bcd_a, 4'h4);
    wait_den(4'b0010, "new1"); chk("new1_bcd", bcd_a, 4'h3);

    // Load coincident with the commit edge is used immediately.
    for (int i = 0; i < 100 && !(m_pos[0] == 23 && !m_idle[0]); i++) @(negedge clk);
    load = 1'b1; digits_in = 16'h5678;
    @(negedge clk);
    load = 1'b0;
    chk("bypass_fd", fd_a, 1'b1);
    chk("bypass_bcd", bcd_a, 4'h8);

    // Disable during digit 2, then restart.
    wait_den(4'b0100, "dis");
    enable = 1'b0;
    @(negedge clk);
    chk("dis_den", den_a, 4'b0);
    chk("dis_fd", fd_a, 1'b0);
    enable = 1'b1;
    @(negedge clk); chk("re_blank0", den_a, 4'b0);
    @(negedge clk); chk("re_blank1", den_a, 4'b0);
    @(negedge clk); chk("re_show0", den_a, 4'b0001); chk("re_show0_bcd", bcd_a, 4'h8);

    lz_case(16'h0050, 4'b0000, LZ_ON ? 4'b0011 : 4'b1111);
    lz_case(16'h0000, 4'b0100, LZ_ON ? 4'b0101 : 4'b1111);
    lz_case(16'h0000, 4'b0000, LZ_ON ? 4'b0001 : 4'b1111);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      load = ($urandom_range(0, 9) == 0);
      if (load) begin
        for (int j = 0; j < 4; j++)
          digits_in[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      end
      if (enable) enable = ($urandom_range(0, 149) != 0);
      else enable = ($urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    load = 1'b0; enable = 1'b1;

    // Asynchronous reset in the middle of a lit digit.
    wait_den(4'b0001, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_den", den_a, 4'b0);
    chk("arst_bcd", bcd_a, 4'h0);
    chk("arst_dp", dp_a, 1'b0);
    chk("arst_fd", fd_a, 1'b0);
    chk("arst_den_b", den_b, 4'b0);
    chk("arst_bcd_b", bcd_b, 4'h0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", den_a, 4'b0);
    enable = 1'b1;
    wait_den(4'b0001, "restart");
    chk("restart_bcd", bcd_a, 4'h0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/bcd_digit_scanner.md
Name: bcd_digit_scanner

Overview:
- Time-multiplexed driver for a multi-digit common-anode/cathode display. Sits directly upstream of the BCD-to-seven-segment decoder.
- Holds NUM_DIGITS packed BCD digits and presents one digit at a time on a 4-bit BCD bus that feeds the decoder's W,X,Y,Z inputs. It also drives a one-hot digit enable.
- Inserts a blanking gap between digits to suppress ghosting.
- Double-buffers the digit data so a display frame never shows a mix of old and new values.

Parameters:
- NUM_DIGITS, 4, number of display digits (2..8).
- PRESCALE, 1000, clock cycles each digit is lit (>=1).
- BLANK_CYCLES, 8, dead cycles before each digit (0 = no blanking state).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; low blanks the display.
- load  in  1  one-cycle strobe; captures digits_in/dp_in into the pending buffer.
- digits_in  in  4*NUM_DIGITS  packed BCD, digit 0 in [3:0] (least significant).
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- bcd_out  out  4  current digit to decoder; [3]=W (MSB) .. [0]=Z.
- digit_en  out  NUM_DIGITS  one-hot, active-high digit select.
- dp_out  out  1  decimal point for current digit.
- frame_done  out  1  one-cycle pulse at end of each full scan.

Behaviour:
- All outputs are registered.
- Reset (rst_n low, async):
  - state=IDLE, idx=0, cnt=0.
  - pending and active buffers cleared to 0.
  - bcd_out=0, digit_en=0, dp_out=0, frame_done=0.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - digit_en=0, frame_done=0.
  - When enable=1: next edge commits pending->active, idx=0, cnt=0, goes to BLANK (or to SHOW if BLANK_CYCLES=0).
- BLANK:
  - digit_en=0.
  - bcd_out/dp_out already show active[idx], so the decoder has settled before the digit lights.
  - Lasts exactly BLANK_CYCLES cycles, then SHOW.
- SHOW:
  - digit_en has only bit idx set.
  - Lasts exactly PRESCALE cycles.
  - On the last cycle: if idx<NUM_DIGITS-1, idx increments and the state returns to BLANK (or SHOW).
  - If idx=NUM_DIGITS-1: idx wraps to 0, frame_done=1 for one cycle, and pending commits to active in the same edge.
- Frame period is NUM_DIGITS*(PRESCALE+BLANK_CYCLES) cycles. The counter is sized to the larger of PRESCALE and BLANK_CYCLES.
- load:
  - Writes the pending buffer only. The active buffer changes only at a frame boundary or on leaving IDLE.
  - Load on the commit edge: the newly loaded value is the one committed (bypass).
  - Load while enable=0: stored, displayed when scanning starts.
- enable falling in any state: next edge goes to IDLE with digit_en=0. idx and cnt reset to 0, frame_done not pulsed.
- BCD values 10..15 pass through unmodified; the decoder defines their pattern.
- Reset asserted mid-scan: all outputs drop to reset values immediately (async). Scanning restarts from digit 0 after release if enable=1.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: during SHOW, digit_en stays 0 for any digit idx>0 whose active value is 0 and whose more significant digits are all 0.
  - dp_in for such a digit overrides suppression, and the digit is shown.
  - Digit 0 is always shown.
  - Slot timing and frame_done are unchanged.
- Undefined: every digit is lit in its slot regardless of value.

Test Plan:
Use NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2 unless stated otherwise.
- Reset/idle: rst_n low mid-SHOW -> digit_en=0, bcd_out=0, frame_done=0 the same cycle. Release with enable=0 -> stays IDLE, digit_en=0.
- Basic scan: load digits_in=16'h9381, enable=1 -> pattern 2 blank, 4 lit repeats. bcd_out sequence 1,8,3,9; digit_en 0001,0010,0100,1000 each 4 cycles. frame_done pulses every 24 cycles.
- Tear-free update: load 16'h1234 mid-frame while showing 16'h9381 -> rest of frame still shows 3,9. Next frame shows 4,3,2,1. Load coincident with frame_done -> new value used immediately.
- Disable mid-scan: enable=0 during digit 2 SHOW -> digit_en=0 next cycle. Re-enable -> scan restarts at digit 0 after 2 blank cycles.
- BLANK_CYCLES=0, PRESCALE=1: digit_en rotates every cycle with no gaps. frame_done every 4 cycles.
- LEADING_ZERO_BLANK_EN defined:
  - digits 16'h0050 -> digit_en never shows 1000 or 0100; digits 1 and 0 lit.
  - dp_in=4'b0100 -> digit 2 lit showing 0.
  - 16'h0000 -> only digit 0 lit.
